// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared arbiter state type and round-robin pointer helper
package rv32i_types;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first requester at or above ptr, wrapping
module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  index
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester is the last one written.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-channel memory arbiter; MEM_ARB_TIMEOUT_EN adds a response watchdog
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  ch_read,
  input  logic [NUM_CH-1:0]                  ch_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]      ch_address,
  input  logic [NUM_CH-1:0][DATA_W-1:0]      ch_wdata,
  input  logic [NUM_CH-1:0][DATA_W/8-1:0]    ch_byte_enable,
  output logic [NUM_CH-1:0]                  ch_resp,
  output logic [DATA_W-1:0]                  ch_rdata,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [ADDR_W-1:0]                  mem_address,
  output logic [DATA_W-1:0]                  mem_wdata,
  output logic [DATA_W/8-1:0]                mem_byte_enable,
  input  logic                               mem_resp,
  input  logic [DATA_W-1:0]                  mem_rdata,
  output logic                               timeout_err
);

  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [NUM_CH-1:0] req;
  logic              timeout_hit;
  logic              done;

  assign req  = ch_read | ch_write;
  assign done = (state == ARB_BUSY) && (mem_resp || timeout_hit);

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // The mem_* registers double as the latched request; clearing them on completion keeps IDLE outputs at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ARB_IDLE;
      rr_ptr          <= '0;
      grant           <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state           <= ARB_BUSY;
            grant           <= pick_idx;
            mem_write       <= ch_write[pick_idx];
            mem_read        <= ~ch_write[pick_idx];
            mem_address     <= ch_address[pick_idx];
            mem_wdata       <= ch_wdata[pick_idx];
            mem_byte_enable <= ch_byte_enable[pick_idx];
          end
        end
        ARB_BUSY: begin
          if (done) begin
            state           <= ARB_IDLE;
            rr_ptr          <= IDX_W'(rr_next(int'(grant), NUM_CH));
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_resp = '0;
    if (state == ARB_BUSY) begin
      ch_resp[grant] = mem_resp | timeout_hit;
    end
  end

  assign ch_rdata = mem_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  assign timeout_hit = (state == ARB_BUSY) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ARB_IDLE) begin
        wd_cnt <= '0;
      end else if (!mem_resp && !timeout_hit) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NC-1:0]         ch_read;
  logic [NC-1:0]         ch_write;
  logic [NC-1:0][AW-1:0] ch_address;
  logic [NC-1:0][DW-1:0] ch_wdata;
  logic [NC-1:0][BW-1:0] ch_byte_enable;
  logic [NC-1:0]         ch_resp;
  logic [DW-1:0]         ch_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [AW-1:0]         mem_address;
  logic [DW-1:0]         mem_wdata;
  logic [BW-1:0]         mem_byte_enable;
  logic                  mem_resp;
  logic [DW-1:0]         mem_rdata;
  logic                  timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_CH         (NC),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_read         (ch_read),
    .ch_write        (ch_write),
    .ch_address      (ch_address),
    .ch_wdata        (ch_wdata),
    .ch_byte_enable  (ch_byte_enable),
    .ch_resp         (ch_resp),
    .ch_rdata        (ch_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .timeout_err     (timeout_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ch_read        = '0;
    ch_write       = '0;
    ch_address     = '0;
    ch_wdata       = '0;
    ch_byte_enable = '0;
    mem_resp       = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    ch_read       = 2'b11;
    ch_write      = 2'b10;
    ch_address[0] = 32'h10;
    mem_resp      = 1'b1;
    step();
    step();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (mem_byte_enable !== 4'h0) begin n_err++; $display("FAIL reset_mem_be: got %h want 0", mem_byte_enable); end
    n_cmp++; if (ch_resp !== 2'b00) begin n_err++; $display("FAIL reset_ch_resp: got %b want 00", ch_resp); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    step();
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_basic_read;
    logic         exp_rd;
    logic [1:0]   exp_resp;
    ch_read       = 2'b01;
    ch_address[0] = 32'h0000_0100;
    for (int c = 0; c <= 4; c++) begin
      if (c == 3) begin mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      if (c == 4) begin mem_resp = 1'b0; ch_read = 2'b00; end
      @(negedge clk);
      exp_rd   = (c >= 1 && c <= 3);
      exp_resp = (c == 3) ? 2'b01 : 2'b00;
      n_cmp++; if (mem_read !== exp_rd) begin n_err++; $display("FAIL basic_mem_read c%0d: got %b want %b", c, mem_read, exp_rd); end
      n_cmp++; if (ch_resp !== exp_resp) begin n_err++; $display("FAIL basic_ch_resp c%0d: got %b want %b", c, ch_resp, exp_resp); end
      if (c == 3) begin
        n_cmp++; if (ch_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL basic_ch_rdata: got %h want deadbeef", ch_rdata); end
        n_cmp++; if (mem_address !== 32'h100) begin n_err++; $display("FAIL basic_mem_address: got %h want 100", mem_address); end
      end
      step();
    end
  endtask

  task automatic test_alternate;
    logic         busy;
    int           g;
    logic [1:0]   exp_resp;
    logic [31:0]  exp_addr;
    do_reset();
    ch_read       = 2'b11;
    ch_address[0] = 32'hA0;
    ch_address[1] = 32'hB0;
    for (int c = 0; c <= 7; c++) begin
      mem_resp = mem_read | mem_write;
      @(negedge clk);
      busy     = (c % 2 == 1);
      g        = ((c - 1) / 2) % 2;
      exp_resp = busy ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_addr = (g == 1) ? 32'hB0 : 32'hA0;
      n_cmp++; if (mem_read !== busy) begin n_err++; $display("FAIL alt_mem_read c%0d: got %b want %b", c, mem_read, busy); end
      n_cmp++; if (ch_resp !== exp_resp) begin n_err++; $display("FAIL alt_ch_resp c%0d: got %b want %b", c, ch_resp, exp_resp); end
      if (busy) begin
        n_cmp++; if (mem_address !== exp_addr) begin n_err++; $display("FAIL alt_grant_addr c%0d: got %h want %h", c, mem_address, exp_addr); end
      end
      step();
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL alt_final_idle: got %b want 0", mem_read); end
    step();
  endtask

  task automatic test_read_write;
    ch_read           = 2'b10;
    ch_write          = 2'b10;
    ch_address[1]     = 32'h40;
    ch_wdata[1]       = 32'h1234_5678;
    ch_byte_enable[1] = 4'hF;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rw_idle_write: got %b want 0", mem_write); end
    step();
    mem_resp = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL rw_mem_write: got %b want 1", mem_write); end
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rw_mem_read: got %b want 0", mem_read); end
    n_cmp++; if (mem_address !== 32'h40) begin n_err++; $display("FAIL rw_mem_address: got %h want 40", mem_address); end
    n_cmp++; if (mem_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL rw_mem_wdata: got %h want 12345678", mem_wdata); end
    n_cmp++; if (mem_byte_enable !== 4'hF) begin n_err++; $display("FAIL rw_mem_be: got %h want f", mem_byte_enable); end
    n_cmp++; if (ch_resp !== 2'b10) begin n_err++; $display("FAIL rw_ch_resp: got %b want 10", ch_resp); end
    step();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rw_after_write: got %b want 0", mem_write); end
    step();
  endtask

  task automatic test_addr_hold;
    ch_read       = 2'b01;
    ch_address[0] = 32'h10;
    @(negedge clk);
    step();
    for (int c = 1; c <= 3; c++) begin
      ch_address[0] = 32'h20;
      if (c == 2) begin ch_write = 2'b01; ch_wdata[0] = 32'h5555_AAAA; end
      if (c == 3) mem_resp = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_address !== 32'h10) begin n_err++; $display("FAIL hold_mem_address c%0d: got %h want 10", c, mem_address); end
      n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL hold_mem_write c%0d: got %b want 0", c, mem_write); end
      step();
    end
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL hold_idle_address: got %h want 0", mem_address); end
    step();
  endtask

  task automatic test_reset_mid;
    ch_read       = 2'b01;
    ch_address[0] = 32'h30;
    @(negedge clk);
    step();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rmid_busy: got %b want 1", mem_read); end
    step();
    #2;
    rst      = 1'b0;
    mem_resp = 1'b1;
    #1;
    n_cmp++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rmid_mem_read_immediate: got %b want 0", mem_read); end
    n_cmp++; if (ch_resp !== 2'b00) begin n_err++; $display("FAIL rmid_ch_resp: got %b want 00", ch_resp); end
    @(negedge clk);
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL rmid_mem_address: got %h want 0", mem_address); end
    step();
    rst = 1'b1;
    clear_inputs();
    ch_read       = 2'b11;
    ch_address[0] = 32'hC0;
    ch_address[1] = 32'hC1;
    @(negedge clk);
    step();
    mem_resp = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_address !== 32'hC0) begin n_err++; $display("FAIL rmid_ptr_after_reset: got %h want c0", mem_address); end
    n_cmp++; if (ch_resp !== 2'b01) begin n_err++; $display("FAIL rmid_resp_after_reset: got %b want 01", ch_resp); end
    step();
    clear_inputs();
    step();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic       exp_rd;
    logic       exp_err;
    logic [1:0] exp_resp;
    do_reset();
    ch_read       = 2'b01;
    ch_address[0] = 32'h50;
    mem_rdata     = 32'hCAFE_F00D;
    for (int c = 0; c <= 8; c++) begin
      if (c == 6) ch_read = 2'b00;
      @(negedge clk);
      exp_rd   = (c >= 1 && c <= 5);
      exp_err  = (c >= 6);
      exp_resp = (c == 5) ? 2'b01 : 2'b00;
      n_cmp++; if (ch_resp !== exp_resp) begin n_err++; $display("FAIL to_ch_resp c%0d: got %b want %b", c, ch_resp, exp_resp); end
      n_cmp++; if (mem_read !== exp_rd) begin n_err++; $display("FAIL to_mem_read c%0d: got %b want %b", c, mem_read, exp_rd); end
      n_cmp++; if (timeout_err !== exp_err) begin n_err++; $display("FAIL to_timeout_err c%0d: got %b want %b", c, timeout_err, exp_err); end
      if (c == 5) begin
        n_cmp++; if (ch_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL to_ch_rdata: got %h want cafef00d", ch_rdata); end
      end
      step();
    end
    clear_inputs();
  endtask
`else
  task automatic test_no_timeout;
    logic       exp_rd;
    logic [1:0] exp_resp;
    do_reset();
    ch_read       = 2'b01;
    ch_address[0] = 32'h50;
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) mem_resp = 1'b1;
      if (c == 11) begin mem_resp = 1'b0; ch_read = 2'b00; end
      @(negedge clk);
      exp_rd   = (c >= 1 && c <= 10);
      exp_resp = (c == 10) ? 2'b01 : 2'b00;
      n_cmp++; if (ch_resp !== exp_resp) begin n_err++; $display("FAIL nto_ch_resp c%0d: got %b want %b", c, ch_resp, exp_resp); end
      n_cmp++; if (mem_read !== exp_rd) begin n_err++; $display("FAIL nto_mem_read c%0d: got %b want %b", c, mem_read, exp_rd); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL nto_timeout_err c%0d: got %b want 0", c, timeout_err); end
      step();
    end
  endtask
`endif

  task automatic test_random;
    logic        m_busy;
    int          m_ptr;
    int          m_g;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [1:0]  exp_resp;
    logic        active [NC];
    logic        got [NC];
    int          kind;
    int          mem_wait;
    logic        mem_prev;
    logic        found;
    int          idx;
    do_reset();
    m_busy   = 1'b0;
    m_ptr    = 0;
    m_g      = 0;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = '0;
    mem_wait = 0;
    mem_prev = 1'b0;
    for (int i = 0; i < NC; i++) begin active[i] = 1'b0; got[i] = 1'b0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (active[i] && got[i]) begin
          ch_read[i]  = 1'b0;
          ch_write[i] = 1'b0;
          active[i]   = 1'b0;
        end else if (!active[i] && $urandom_range(0, 2) == 0) begin
          active[i]   = 1'b1;
          kind        = int'($urandom_range(0, 2));
          ch_read[i]  = (kind != 1);
          ch_write[i] = (kind != 0);
        end
        ch_address[i]     = $urandom;
        ch_wdata[i]       = $urandom;
        ch_byte_enable[i] = 4'($urandom);
      end
      if (mem_read || mem_write) begin
        if (!mem_prev) mem_wait = int'($urandom_range(0, 2));
        mem_resp = (mem_wait == 0);
        mem_wait--;
        mem_prev = 1'b1;
      end else begin
        mem_prev = 1'b0;
        mem_resp = ($urandom_range(0, 3) == 0);
      end
      mem_rdata = $urandom;
      @(negedge clk);
      exp_resp = '0;
      if (m_busy && mem_resp) exp_resp[m_g] = 1'b1;
      n_cmp++; if (mem_read !== (m_busy && !m_wr)) begin n_err++; $display("FAIL rnd_mem_read cyc%0d: got %b want %b", cyc, mem_read, m_busy && !m_wr); end
      n_cmp++; if (mem_write !== (m_busy && m_wr)) begin n_err++; $display("FAIL rnd_mem_write cyc%0d: got %b want %b", cyc, mem_write, m_busy && m_wr); end
      n_cmp++; if (mem_address !== (m_busy ? m_addr : 32'h0)) begin n_err++; $display("FAIL rnd_mem_address cyc%0d: got %h want %h", cyc, mem_address, m_busy ? m_addr : 32'h0); end
      n_cmp++; if (mem_wdata !== (m_busy ? m_wdata : 32'h0)) begin n_err++; $display("FAIL rnd_mem_wdata cyc%0d: got %h want %h", cyc, mem_wdata, m_busy ? m_wdata : 32'h0); end
      n_cmp++; if (mem_byte_enable !== (m_busy ? m_be : 4'h0)) begin n_err++; $display("FAIL rnd_mem_be cyc%0d: got %h want %h", cyc, mem_byte_enable, m_busy ? m_be : 4'h0); end
      n_cmp++; if (ch_resp !== exp_resp) begin n_err++; $display("FAIL rnd_ch_resp cyc%0d: got %b want %b", cyc, ch_resp, exp_resp); end
      n_cmp++; if (ch_rdata !== mem_rdata) begin n_err++; $display("FAIL rnd_ch_rdata cyc%0d: got %h want %h", cyc, ch_rdata, mem_rdata); end
      for (int i = 0; i < NC; i++) got[i] = exp_resp[i];
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < NC; k++) begin
          idx = (m_ptr + k) % NC;
          if (!found && (ch_read[idx] || ch_write[idx])) begin
            found   = 1'b1;
            m_busy  = 1'b1;
            m_g     = idx;
            m_wr    = ch_write[idx];
            m_addr  = ch_address[idx];
            m_wdata = ch_wdata[idx];
            m_be    = ch_byte_enable[idx];
          end
        end
      end else if (mem_resp) begin
        m_busy = 1'b0;
        m_ptr  = (m_g + 1) % NC;
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_basic_read();
    test_alternate();
    test_read_write();
    test_addr_hold();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
